// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder (package data_sram_params).
// Holds the request and queue-entry layouts plus the stall LFSR helper used when
// DATA_SRAM_RESPONDER_RANDOM_STALL_EN is defined.
package data_sram_params;

  // Longest supported request-to-response latency; sizes the per-entry countdown.
  localparam int RESPONSE_LATENCY_MAX = 15;
  localparam int COUNTDOWN_WIDTH      = $clog2(RESPONSE_LATENCY_MAX + 1);

  // Seed loaded into the stall LFSR on reset.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [31:0] cpu_data_t;

  // One request as presented by the CPU side.
  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [3:0]  strobe;
    cpu_data_t   data;
  } data_sram_request_t;

  // One slot of the in-order request queue.
  typedef struct packed {
    data_sram_request_t          request;
    logic [COUNTDOWN_WIDTH-1:0]  countdown;
  } queue_entry_t;

  // Next state of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  endfunction

endpackage

// File: rtl/data_sram_byte_memory.sv
// Word-addressed data array with byte-strobe writes. Writes land on the clock
// edge; reads are combinational from the same index. Contents are never reset.
module data_sram_byte_memory
  import data_sram_params::*;
#(
  parameter int MEMORY_INDEX_WIDTH = 12
) (
  input  logic                          clock,
  input  logic                          write_enable,
  input  logic [MEMORY_INDEX_WIDTH-1:0] index,
  input  logic [3:0]                    strobe,
  input  cpu_data_t                     write_data,
  output cpu_data_t                     read_data
);

  cpu_data_t words [2**MEMORY_INDEX_WIDTH];

  // Byte-granular write of the selected word.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe[b]) begin
          words[index][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

  assign read_data = words[index];

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-SRAM request/response interface.
// Requests are accepted into an in-order queue, each entry counts down its
// latency, and the head retires (at most one per cycle) into a registered
// one-cycle data-ready pulse. Optional macro DATA_SRAM_RESPONDER_RANDOM_STALL_EN
// adds an LFSR that randomly refuses requests and defers retirement.
//
// Handshake: a request transfers on a rising clock edge where request_valid and
// request_address_ok are both high. request_address_ok depends only on
// registered state, never on request_valid. The response side has no ready:
// every data_ram_data_ready pulse must be consumed in the cycle it appears.
module data_sram_responder
  import data_sram_params::*;
#(
  parameter int MEMORY_INDEX_WIDTH = 12,
  parameter int RESPONSE_LATENCY   = 2,
  parameter int QUEUE_DEPTH        = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               request_valid,
  input  logic                               request_write,
  input  logic [31:0]                        request_address,
  input  logic [3:0]                         request_write_strobe,
  input  logic [31:0]                        request_write_data,
  output logic                               request_address_ok,
  output logic [31:0]                        data_ram_read_data,
  output logic                               data_ram_data_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   outstanding_count
);

  localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH);
  localparam int COUNT_WIDTH = $clog2(QUEUE_DEPTH + 1);
  localparam logic [COUNTDOWN_WIDTH-1:0] COUNTDOWN_INIT =
    COUNTDOWN_WIDTH'(RESPONSE_LATENCY - 1);

  queue_entry_t           queue [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] slot_valid;
  logic [PTR_WIDTH-1:0]   head;
  logic [PTR_WIDTH-1:0]   tail;
  logic [COUNT_WIDTH-1:0] count;
  queue_entry_t           head_entry;
  logic                   accept;
  logic                   retire;
  logic                   accept_allowed;
  logic                   retire_allowed;
  cpu_data_t              memory_read_data;
  logic                   unused_head_address;

`ifdef DATA_SRAM_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Free-running stall source; bit 0 blocks acceptance, bit 1 defers retire.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign accept_allowed = !lfsr[0];
  assign retire_allowed = !lfsr[1];
`else
  assign accept_allowed = 1'b1;
  assign retire_allowed = 1'b1;
`endif

  // A full queue refuses even if the head retires this cycle: no fall-through.
  assign request_address_ok = (count < COUNT_WIDTH'(QUEUE_DEPTH)) && accept_allowed;
  assign accept             = request_valid && request_address_ok;
  assign head_entry         = queue[head];
  assign retire             = slot_valid[head] && (head_entry.countdown == '0) && retire_allowed;
  assign outstanding_count  = count;

  // Upper address bits only alias; they are carried in the entry but not used.
  assign unused_head_address = ^head_entry.request.address;

  // Queue bookkeeping: parallel countdowns, enqueue at tail, retire at head.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (slot_valid[i] && (queue[i].countdown != '0)) begin
          queue[i].countdown <= queue[i].countdown - COUNTDOWN_WIDTH'(1);
        end
      end
      if (accept) begin
        queue[tail].request.write   <= request_write;
        queue[tail].request.address <= request_address;
        queue[tail].request.strobe  <= request_write_strobe;
        queue[tail].request.data    <= request_write_data;
        queue[tail].countdown       <= COUNTDOWN_INIT;
        slot_valid[tail]            <= 1'b1;
        tail                        <= tail + PTR_WIDTH'(1);
      end
      if (retire) begin
        slot_valid[head] <= 1'b0;
        head             <= head + PTR_WIDTH'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // The retiring head is the only memory user: writes commit, reads sample.
  data_sram_byte_memory #(
    .MEMORY_INDEX_WIDTH (MEMORY_INDEX_WIDTH)
  ) u_memory (
    .clock        (clock),
    .write_enable (retire && head_entry.request.write),
    .index        (head_entry.request.address[MEMORY_INDEX_WIDTH+1:2]),
    .strobe       (head_entry.request.strobe),
    .write_data   (head_entry.request.data),
    .read_data    (memory_read_data)
  );

  // Registered response: one pulse per retire, data only for reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_ram_data_ready <= 1'b0;
      data_ram_read_data  <= '0;
    end else begin
      data_ram_data_ready <= retire;
      data_ram_read_data  <= (retire && !head_entry.request.write) ? memory_read_data : '0;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: random and directed traffic against a
// reference model of memory contents and response timing, checked by a
// negedge monitor. A second, slow instance exercises the full-queue and
// mid-operation reset behaviour.
module tb_data_sram_responder;

  localparam int L      = 2;
  localparam int QD     = 4;
  localparam int MIW    = 12;
  localparam int SLOW_L = 8;
  localparam int CW     = $clog2(QD + 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, request_valid, request_write, request_address_ok, data_ram_data_ready;
  logic [31:0]   request_address, request_write_data, data_ram_read_data;
  logic [3:0]    request_write_strobe;
  logic [CW-1:0] outstanding_count;

  logic          s_reset, s_valid, s_write, s_ok, s_ready;
  logic [31:0]   s_address, s_data, s_read_data;
  logic [3:0]    s_strobe;
  logic [CW-1:0] s_count;

  data_sram_responder #(
    .MEMORY_INDEX_WIDTH (MIW), .RESPONSE_LATENCY (L), .QUEUE_DEPTH (QD)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .request_valid        (request_valid),
    .request_write        (request_write),
    .request_address      (request_address),
    .request_write_strobe (request_write_strobe),
    .request_write_data   (request_write_data),
    .request_address_ok   (request_address_ok),
    .data_ram_read_data   (data_ram_read_data),
    .data_ram_data_ready  (data_ram_data_ready),
    .outstanding_count    (outstanding_count)
  );

  data_sram_responder #(
    .MEMORY_INDEX_WIDTH (MIW), .RESPONSE_LATENCY (SLOW_L), .QUEUE_DEPTH (QD)
  ) slow_dut (
    .clock                (clock),
    .reset                (s_reset),
    .request_valid        (s_valid),
    .request_write        (s_write),
    .request_address      (s_address),
    .request_write_strobe (s_strobe),
    .request_write_data   (s_data),
    .request_address_ok   (s_ok),
    .data_ram_read_data   (s_read_data),
    .data_ram_data_ready  (s_ready),
    .outstanding_count    (s_count)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          timing_q[$];
  logic [31:0] model_mem [int];
  int          cycle = 0;
  int          last_retire = 0;
  int          accepts = 0;
  int          pulses = 0;
  bit          monitor_on = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, actual, expected, cycle);
    end
  endtask

  // Reference model: requests take effect in acceptance order; response edge
  // is the later of accept+latency and one edge after the previous response.
  function automatic void model_accept(input logic w, input logic [31:0] a,
                                       input logic [3:0] s, input logic [31:0] d,
                                       input int edge_no);
    int          idx = int'(a[MIW+1:2]);
    logic [31:0] word;
    int          ret;
    word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
      model_mem[idx] = word;
      exp_q.push_back(32'h0);
    end else begin
      exp_q.push_back(word);
    end
    ret = (edge_no + L > last_retire + 1) ? edge_no + L : last_retire + 1;
    last_retire = ret;
    timing_q.push_back(ret);
    accepts++;
  endfunction

  function automatic logic [31:0] rand_addr(input int word);
    return ($urandom() & 32'hFFFF_C003) | (32'(word) << 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int waited = 0;
    request_valid        = 1'b1;
    request_write        = w;
    request_address      = a;
    request_write_strobe = s;
    request_write_data   = d;
    #1;
    while (!request_address_ok && waited < 100) begin
      @(negedge clock); #1;
      waited++;
    end
    if (!request_address_ok) begin
      check("accept_timeout", {31'b0, request_address_ok}, 32'h1);
      request_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      model_accept(w, a, s, d, cycle);
      @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    request_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (monitor_on) begin
      if (data_ram_data_ready) begin
        pulses++;
        if (exp_q.size() == 0) check("unexpected_pulse", {31'b0, data_ram_data_ready}, 32'h0);
        else check("read_data", data_ram_read_data, exp_q.pop_front());
      end
`ifndef DATA_SRAM_RESPONDER_RANDOM_STALL_EN
      begin
        bit exp_pulse;
        exp_pulse = (timing_q.size() > 0) && (timing_q[0] == cycle);
        if (exp_pulse) void'(timing_q.pop_front());
        check("pulse_timing", {31'b0, data_ram_data_ready}, {31'b0, exp_pulse});
        check("outstanding_count", 32'(outstanding_count), 32'(timing_q.size()));
        check("address_ok", {31'b0, request_address_ok}, {31'b0, timing_q.size() < QD});
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          c0, n_acc, budget, slow_pulses;
    int          acc_edge[6];
    int          pulse_edge[$];
    logic        took;
    int          exp_edges[5];

    reset = 1'b1; request_valid = 1'b0; request_write = 1'b0; request_address = '0;
    request_write_strobe = '0; request_write_data = '0;
    s_reset = 1'b1; s_valid = 1'b0; s_write = 1'b0; s_address = '0; s_strobe = '0; s_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; s_reset = 1'b0;
    #1;
    check("reset_count", 32'(outstanding_count), 32'h0);
    check("reset_ready", {31'b0, data_ram_data_ready}, 32'h0);
    check("reset_read_data", data_ram_read_data, 32'h0);
`ifndef DATA_SRAM_RESPONDER_RANDOM_STALL_EN
    check("reset_ok", {31'b0, request_address_ok}, 32'h1);
`endif
    @(negedge clock);
    monitor_on = 1'b1;

    // Full write then read of the same word.
    send(1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678);
    send(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    idle(4);
    // Partial-strobe write over a cleared word, then read back.
    send(1'b1, 32'h0000_0104, 4'hF, 32'h0000_0000);
    send(1'b1, 32'h0000_0104, 4'b0101, 32'hAABB_CCDD);
    send(1'b0, 32'h0000_0104, 4'h0, 32'h0);
    // Zero-strobe write leaves the word, aliased read via upper bits.
    send(1'b1, 32'h0000_0104, 4'b0000, 32'hFFFF_FFFF);
    send(1'b0, 32'h8000_4105, 4'h0, 32'h0);
    send(1'b0, 32'h8000_4101, 4'h0, 32'h0);
    idle(3);

    // Preload a 16-word window back-to-back (pointer wrap), then random traffic.
    for (int w = 0; w < 16; w++) send(1'b1, rand_addr(w), 4'hF, $urandom());
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)), rand_addr($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom());
    end
    idle(1);

`ifndef DATA_SRAM_RESPONDER_RANDOM_STALL_EN
    // Slow instance: fill the queue, hold a fifth request across the first retire.
    c0 = cycle; n_acc = 0;
    s_valid = 1'b1; s_write = 1'b1; s_strobe = 4'h0; s_address = 32'h0; s_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 24; k++) begin
      #1;
      took = s_valid && s_ok;
      @(posedge clock); #1;
      if (took) begin
        acc_edge[n_acc] = cycle;
        n_acc++;
        if (n_acc == 5) s_valid = 1'b0;
      end
      @(negedge clock); #1;
      if (s_ready) begin
        pulse_edge.push_back(cycle);
        check("slow_write_data", s_read_data, 32'h0);
      end
      if (cycle == c0 + 4) begin
        check("full_count", 32'(s_count), 32'd4);
        check("full_ok", {31'b0, s_ok}, 32'h0);
      end
    end
    check("slow_accepts", 32'(n_acc), 32'd5);
    if (n_acc == 5) check("no_fall_through", 32'(acc_edge[4] - c0), 32'd10);
    exp_edges = '{9, 10, 11, 12, 18};
    check("slow_pulse_count", 32'(pulse_edge.size()), 32'd5);
    for (int i = 0; i < 5 && i < pulse_edge.size(); i++)
      check("slow_pulse_edge", 32'(pulse_edge[i] - c0), 32'(exp_edges[i]));

    // Slow instance: reset with three requests outstanding.
    @(negedge clock);
    s_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    s_valid = 1'b0;
    #1;
    check("pre_reset_count", 32'(s_count), 32'd3);
    s_reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    s_reset = 1'b0;
    slow_pulses = 0;
    repeat (15) begin
      @(negedge clock); #1;
      if (s_ready) slow_pulses++;
    end
    check("post_reset_pulses", 32'(slow_pulses), 32'd0);
    check("post_reset_count", 32'(s_count), 32'd0);
    check("post_reset_ok", {31'b0, s_ok}, 32'h1);
    check("post_reset_data", s_read_data, 32'h0);
`endif

    // Drain and final accounting.
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    repeat (5) @(negedge clock);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("pulse_count", 32'(pulses), 32'(accepts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
